// File: rtl/ccu_pkg.sv
// Shared definitions for the CCU sequencers: order codes, sequencer states,
// minor-cycle timing defaults and the shift-count saturation helper.
package ccu_pkg;

    localparam int MC_LEN_DEF = 36;
    localparam int STEP_W     = 6;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_MULT = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_SHR  = 2'b11;

    localparam logic [STEP_W-1:0] MAX_PLACES = 6'd35;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ALIGN = 2'b01,
        RUN   = 2'b10,
        DONE  = 2'b11
    } ccu_state_e;

    function automatic logic [STEP_W-1:0] sat_places(input logic [STEP_W-1:0] places);
        if (places > MAX_PLACES) begin
            sat_places = MAX_PLACES;
        end else begin
            sat_places = places;
        end
    endfunction

endpackage

// File: rtl/ccu_seq_if.sv
// Order request / gating strobe bundle between the main order sequencer, ccu_seq
// and the CCU 2 datapath. Defining CCU_SEQ_ABORT_EN adds the abort request line.
interface ccu_seq_if;
    import ccu_pkg::*;

    logic              start;
    logic [1:0]        op;
    logic              long_num;
    logic [STEP_W-1:0] count;
`ifdef CCU_SEQ_ABORT_EN
    logic              abort;
`endif
    logic              busy;
    logic              done;
    logic              ovr;
    logic              d0;
    logic              d35;
    logic              c5;
    logic              c6;
    logic              s2;
    logic              c7;
    logic [STEP_W-1:0] step;

`ifdef CCU_SEQ_ABORT_EN
    modport master (
        output start, op, long_num, count, abort,
        input  busy, done, ovr, d0, d35, c5, c6, s2, c7, step
    );
    modport slave (
        input  start, op, long_num, count, abort,
        output busy, done, ovr, d0, d35, c5, c6, s2, c7, step
    );
`else
    modport master (
        output start, op, long_num, count,
        input  busy, done, ovr, d0, d35, c5, c6, s2, c7, step
    );
    modport slave (
        input  start, op, long_num, count,
        output busy, done, ovr, d0, d35, c5, c6, s2, c7, step
    );
`endif

endinterface

// File: rtl/ccu_digit_timer.sv
// Free-running pulse-interval counter (0..MC_LEN-1) with first/last digit decode.
// Shared by every CCU that needs minor-cycle framing.
module ccu_digit_timer
    import ccu_pkg::*;
#(
    parameter int MC_LEN = MC_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic d0,
    output logic d35
);

    localparam int              PI_W    = (MC_LEN > 1) ? $clog2(MC_LEN) : 1;
    localparam logic [PI_W-1:0] PI_LAST = PI_W'(MC_LEN - 1);
    localparam logic [PI_W-1:0] PI_ZERO = {PI_W{1'b0}};
    localparam logic [PI_W-1:0] PI_ONE  = PI_W'(1);

    logic [PI_W-1:0] pi_r;
    logic [PI_W-1:0] pi_nxt_s;
    logic            d0_r;
    logic            d35_r;

    // Next p.i. value, wrapping at the end of the minor cycle.
    always_comb begin
        pi_nxt_s = pi_r;
        if (pi_r == PI_LAST) begin
            pi_nxt_s = PI_ZERO;
        end else begin
            pi_nxt_s = pi_r + PI_ONE;
        end
    end

    // Counter and digit decodes registered together so d0/d35 track the counter exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pi_r  <= PI_ZERO;
            d0_r  <= 1'b1;
            d35_r <= 1'b0;
        end else begin
            pi_r  <= pi_nxt_s;
            d0_r  <= (pi_nxt_s == PI_ZERO);
            d35_r <= (pi_nxt_s == PI_LAST);
        end
    end

    assign d0  = d0_r;
    assign d35 = d35_r;

endmodule

// File: rtl/ccu_seq.sv
// Multiply/shift order sequencer: aligns an accepted order to the minor cycle,
// runs one step per minor cycle and drives the CCU 2 gating strobes.
// Defining CCU_SEQ_ABORT_EN adds abort, which ends the order at the next d35.
module ccu_seq
    import ccu_pkg::*;
#(
    parameter int MC_LEN      = MC_LEN_DEF,
    parameter int SHORT_STEPS = 17,
    parameter int LONG_STEPS  = 35
) (
    input logic      clk,
    input logic      rst,
    ccu_seq_if.slave bus
);

    localparam logic [STEP_W-1:0] SHORT_N  = STEP_W'(SHORT_STEPS);
    localparam logic [STEP_W-1:0] LONG_N   = STEP_W'(LONG_STEPS);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};

    ccu_state_e        state_r;
    ccu_state_e        state_nxt_s;
    logic [1:0]        op_r;
    logic              long_r;
    logic [STEP_W-1:0] places_r;
    logic [STEP_W-1:0] step_r;
    logic [STEP_W-1:0] target_s;
    logic              d0_s;
    logic              d35_s;
    logic              accept_s;
    logic              last_step_s;
    logic              abort_now_s;
    logic              run_s;

    ccu_digit_timer #(
        .MC_LEN (MC_LEN)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .d0  (d0_s),
        .d35 (d35_s)
    );

    assign accept_s    = (state_r == IDLE) && bus.start && (bus.op != OP_NONE);
    assign last_step_s = ((step_r + STEP_ONE) == target_s);
    assign run_s       = (state_r == RUN);

    // Step target of the latched order.
    always_comb begin
        target_s = places_r;
        if (op_r == OP_MULT) begin
            target_s = long_r ? LONG_N : SHORT_N;
        end else begin
            target_s = places_r;
        end
    end

`ifdef CCU_SEQ_ABORT_EN
    logic abort_pend_r;

    // An abort seen mid-cycle is remembered until the d35 that honours it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abort_pend_r <= 1'b0;
        end else if (accept_s) begin
            abort_pend_r <= 1'b0;
        end else if (((state_r == ALIGN) || (state_r == RUN)) && bus.abort) begin
            abort_pend_r <= 1'b1;
        end else begin
            abort_pend_r <= abort_pend_r;
        end
    end

    assign abort_now_s = abort_pend_r |
                         (bus.abort & ((state_r == ALIGN) || (state_r == RUN)));
`else
    assign abort_now_s = 1'b0;
`endif

    // Sequencer next-state logic; transitions out of ALIGN/RUN happen only on d35.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ALIGN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ALIGN: begin
                if (d35_s && ((target_s == STEP_ZERO) || abort_now_s)) begin
                    state_nxt_s = DONE;
                end else if (d35_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = ALIGN;
                end
            end
            RUN: begin
                if (d35_s && (last_step_s || abort_now_s)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Order latch and step counter; step survives DONE until the next acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= OP_NONE;
            long_r   <= 1'b0;
            places_r <= STEP_ZERO;
            step_r   <= STEP_ZERO;
        end else if (accept_s) begin
            op_r     <= bus.op;
            long_r   <= bus.long_num;
            places_r <= sat_places(bus.count);
            step_r   <= STEP_ZERO;
        end else if (d35_s && (state_r == ALIGN)) begin
            step_r   <= STEP_ZERO;
        end else if (d35_s && run_s) begin
            step_r   <= step_r + STEP_ONE;
        end else begin
            step_r   <= step_r;
        end
    end

    assign bus.busy = (state_r != IDLE);
    assign bus.done = (state_r == DONE);
    assign bus.ovr  = bus.start && (state_r != IDLE);
    assign bus.d0   = d0_s;
    assign bus.d35  = d35_s;
    assign bus.c5   = run_s && (op_r == OP_MULT);
    assign bus.c6   = run_s && op_r[1];
    assign bus.s2   = run_s && (op_r == OP_SHL);
    assign bus.c7   = run_s && d35_s;
    assign bus.step = step_r;

endmodule

// File: tb/tb_ccu_seq.sv
// Randomized self-checking bench for ccu_seq against a timeline model that
// predicts each order's accept, RUN start and done cycles arithmetically.
module tb_ccu_seq;
    import ccu_pkg::*;

    localparam int MC      = 36;
    localparam int SHORT_N = 17;
    localparam int LONG_N  = 35;

    logic clk;
    logic rst;

    int checks;
    int errors;

    // Reference model: cycle index since reset release and the current order's timeline.
    int         t;
    bit         ord_valid;
    int         acc_t;
    int         run_t;
    int         done_t;
    int         fin_n;
    int         prev_step;
    logic [1:0] ord_op;

    int c7_seen;
    int done_seen;

    ccu_seq_if bus ();

    ccu_seq #(
        .MC_LEN      (MC),
        .SHORT_STEPS (SHORT_N),
        .LONG_STEPS  (LONG_N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, t);
        end
    endtask

    function automatic bit busy_now();
        return ord_valid && (t > acc_t) && (t <= done_t);
    endfunction

    function automatic int step_now();
        if (!ord_valid || t <= acc_t) return prev_step;
        if (t >= done_t) return fin_n;
        if (t < run_t) return 0;
        return (t - run_t) / MC;
    endfunction

    task automatic model_reset();
        t = 0; ord_valid = 1'b0; acc_t = 0; run_t = 0; done_t = 0;
        fin_n = 0; prev_step = 0; ord_op = 2'b00;
    endtask

    task automatic check_cycle();
        int pi;
        bit in_run;
        pi     = t % MC;
        in_run = ord_valid && (t >= run_t) && (t < done_t);
        check_eq("d0",   int'(bus.d0),   int'(pi == 0));
        check_eq("d35",  int'(bus.d35),  int'(pi == MC - 1));
        check_eq("busy", int'(bus.busy), int'(busy_now()));
        check_eq("done", int'(bus.done), int'(ord_valid && t == done_t));
        check_eq("ovr",  int'(bus.ovr),  int'(bus.start && busy_now()));
        check_eq("c5",   int'(bus.c5),   int'(in_run && ord_op == 2'b01));
        check_eq("c6",   int'(bus.c6),   int'(in_run && ord_op[1]));
        check_eq("s2",   int'(bus.s2),   int'(in_run && ord_op == 2'b10));
        check_eq("c7",   int'(bus.c7),   int'(in_run && pi == MC - 1));
        check_eq("step", int'(bus.step), step_now());
    endtask

    task automatic model_edge();
        int a;
        int n;
        int d;
        if (bus.start && bus.op != 2'b00 && !busy_now()) begin
            prev_step = step_now();
            if (bus.op == 2'b01) n = bus.long_num ? LONG_N : SHORT_N;
            else                 n = (int'(bus.count) > 35) ? 35 : int'(bus.count);
            a         = (t + 1) % MC;
            acc_t     = t;
            run_t     = t + 1 + (MC - 1 - a) + 1;
            done_t    = run_t + n * MC;
            fin_n     = n;
            ord_op    = bus.op;
            ord_valid = 1'b1;
        end
`ifdef CCU_SEQ_ABORT_EN
        else if (bus.abort && ord_valid && t > acc_t && t < done_t) begin
            d = t + (MC - 1 - (t % MC));
            if (d + 1 < done_t) begin
                done_t = d + 1;
                fin_n  = (d < run_t) ? 0 : (d - run_t) / MC + 1;
            end
        end
`endif
        d = 0;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_cycle();
        c7_seen   += int'(bus.c7);
        done_seen += int'(bus.done);
        model_edge();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic issue(input logic [1:0] op, input logic lng, input logic [5:0] cnt);
        c7_seen      = 0;
        done_seen    = 0;
        bus.start    = 1'b1;
        bus.op       = op;
        bus.long_num = lng;
        bus.count    = cnt;
        run_cycle();
        bus.start    = 1'b0;
        bus.op       = 2'($urandom_range(0, 3));
        bus.long_num = 1'($urandom_range(0, 1));
        bus.count    = 6'($urandom_range(0, 63));
    endtask

    task automatic wait_pi(input int p);
        while ((t % MC) != p) run_cycle();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_now() || bus.busy) && n < 3000) begin
            run_cycle();
            n++;
        end
        if (n >= 3000) check_eq("idle_timeout", int'(bus.busy), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_d0"},   int'(bus.d0),   1);
        check_eq({tag, "_d35"},  int'(bus.d35),  0);
        check_eq({tag, "_busy"}, int'(bus.busy), 0);
        check_eq({tag, "_done"}, int'(bus.done), 0);
        check_eq({tag, "_ovr"},  int'(bus.ovr),  0);
        check_eq({tag, "_c5"},   int'(bus.c5),   0);
        check_eq({tag, "_c6"},   int'(bus.c6),   0);
        check_eq({tag, "_s2"},   int'(bus.s2),   0);
        check_eq({tag, "_c7"},   int'(bus.c7),   0);
        check_eq({tag, "_step"}, int'(bus.step), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", t);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks = 0; errors = 0;
        c7_seen = 0; done_seen = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.long_num = 1'b0; bus.count = 6'd0;
`ifdef CCU_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // Short multiply started at p.i. 10.
        wait_pi(10);
        issue(2'b01, 1'b0, 6'd0);
        wait_idle();
        check_eq("t1_step", int'(bus.step), 17);
        check_eq("t1_c7",   c7_seen, 17);
        check_eq("t1_done", done_seen, 1);

        // Shift left 5 places started at p.i. 35.
        wait_pi(35);
        issue(2'b10, 1'b0, 6'd5);
        wait_idle();
        check_eq("t2_step", int'(bus.step), 5);
        check_eq("t2_c7",   c7_seen, 5);

        // Shift right by zero places: no RUN at all.
        repeat ($urandom_range(1, 50)) run_cycle();
        issue(2'b11, 1'b0, 6'd0);
        wait_idle();
        check_eq("t3_step", int'(bus.step), 0);
        check_eq("t3_c7",   c7_seen, 0);
        check_eq("t3_done", done_seen, 1);

        // Oversized count saturates; a second start mid-RUN is refused.
        issue(2'b11, 1'b0, 6'd50);
        repeat (100) run_cycle();
        bus.start = 1'b1; bus.op = 2'b01; bus.count = 6'd3;
        run_cycle();
        bus.start = 1'b0;
        wait_idle();
        check_eq("t4_step", int'(bus.step), 35);
        check_eq("t4_c7",   c7_seen, 35);

        // Reset in RUN step 8, then a normal order.
        issue(2'b01, 1'b1, 6'd0);
        n = 0;
        while (step_now() < 8 && n < 2000) begin run_cycle(); n++; end
        repeat (10) run_cycle();
        check_eq("t5_pre_step", int'(bus.step), 8);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("t5_async");
        repeat (2) begin
            @(negedge clk);
            check_reset_vals("t5_hold");
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        issue(2'b01, 1'b0, 6'd0);
        wait_idle();
        check_eq("t5_step", int'(bus.step), 17);
        check_eq("t5_done", done_seen, 1);

`ifdef CCU_SEQ_ABORT_EN
        // Abort of a long multiply in the middle of step 3.
        issue(2'b01, 1'b1, 6'd0);
        n = 0;
        while (step_now() < 3 && n < 2000) begin run_cycle(); n++; end
        repeat (10) run_cycle();
        bus.abort = 1'b1;
        run_cycle();
        bus.abort = 1'b0;
        wait_idle();
        check_eq("t6_step", int'(bus.step), 4);
        check_eq("t6_c7",   c7_seen, 4);
        check_eq("t6_done", done_seen, 1);
`endif

        // Random orders with stray starts (and aborts when enabled) while busy.
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 40)) run_cycle();
            issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
            n = 0;
            while (busy_now() && n < 3000) begin
                if ($urandom_range(0, 63) == 0) begin
                    bus.start = 1'b1;
                    bus.op    = 2'($urandom_range(0, 3));
                end
`ifdef CCU_SEQ_ABORT_EN
                if ($urandom_range(0, 299) == 0) bus.abort = 1'b1;
`endif
                run_cycle();
                bus.start = 1'b0;
`ifdef CCU_SEQ_ABORT_EN
                bus.abort = 1'b0;
`endif
                n++;
            end
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ccu_seq.md
# ccu_seq

Sequencer for the multiply/shift arithmetic path of the control section. It accepts one order at a time: multiply (short or long) or shift (left or right, 1–35 places). It aligns the order to the minor-cycle boundary and runs one step per minor cycle. It drives the gating strobes that the CCU 2 datapath consumes, plus a done pulse back to the main order sequencer. It also owns the pulse-interval (p.i.) digit timer that generates d0/d35 for the arithmetic path.

## Interface
Parameters:
- MC_LEN, 36: pulse intervals per minor cycle.
- SHORT_STEPS, 17: multiply steps for a short-number order.
- LONG_STEPS, 35: multiply steps for a long-number order.

Ports:
- clk  in  1  system clock; one cycle = one pulse interval.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  order request; sampled every cycle.
- op  in  2  order code: 00 none, 01 multiply, 10 shift left, 11 shift right.
- long_num  in  1  multiply uses LONG_STEPS when 1, SHORT_STEPS when 0.
- count  in  6  shift places, 0–35; values above 35 saturate to 35.
- busy  out  1  order accepted and not yet complete.
- done  out  1  one-cycle completion pulse.
- ovr  out  1  one-cycle pulse on an ignored start.
- d0  out  1  high when p.i. counter = 0.
- d35  out  1  high when p.i. counter = MC_LEN-1.
- c5  out  1  multiply gate.
- c6  out  1  shift gate.
- s2  out  1  shift direction during RUN: 1 = left, 0 = right.
- c7  out  1  step-commit strobe.
- step  out  6  number of completed steps in the current order.

## Operation
- The p.i. counter is free-running, 0..MC_LEN-1, and wraps to 0. It never stalls.
- Orders latched on acceptance: op, long_num and count (saturated). Later input changes are ignored.
- Step target N: multiply → long_num ? LONG_STEPS : SHORT_STEPS; shift → latched count.
- IDLE:
  - start with op≠00 → latch the order, go to ALIGN.
  - start with op=00 → ignored, no ovr.
- ALIGN: wait for d35.
  - At d35 with N=0 → go to DONE.
  - At d35 otherwise → go to RUN; step is cleared.
- RUN:
  - c5 = (op=01); c6 = op[1]; s2 = (op=10).
  - c7 = d35.
  - At each d35: step increments.
  - At the d35 where step becomes N → go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
  - busy is high in ALIGN, RUN and DONE.
  - step holds its final value until the next acceptance.
- start while busy → ignored; ovr pulses for that cycle.
- start in the DONE cycle is also ignored (ovr=1). Acceptance is only in IDLE.

## Timing
- Reset values:
  - state IDLE, p.i. counter 0, step 0.
  - busy, done, ovr, c5, c6, s2, c7 all 0.
  - d0=1 (counter is 0 during reset).
- Acceptance → ALIGN takes 1 cycle.
- RUN always begins on a d0 cycle.
- Total latency from accept to done = (cycles to next d35) + N·MC_LEN + 1.
  - Worked case: accept at p.i. 35 → ALIGN entered at p.i. 0 → waits 35 cycles → RUN begins at next d0.
  - If ALIGN is entered exactly on a d35 cycle, it exits that same cycle.
- c5/c6/s2 are asserted from the first d0 of RUN through the final d35 inclusive. They are 0 in the DONE cycle.
- c7 pulses N times per order, always coincident with d35.
- Reset asserted mid-order: immediate return to reset values. No done is issued.

## Configuration
- CCU_SEQ_ABORT_EN
  - Defined: adds an input port abort (1 bit). In ALIGN or RUN, abort=1 forces the state to DONE at the next d35. That DONE produces the done pulse, step keeps its partial count, and no further c7 is issued after that d35. abort is ignored in IDLE and DONE.
  - Undefined: no abort port; orders always run to N steps.

## Structure
- Shared package ccu_pkg holds:
  - op code constants (OP_NONE, OP_MULT, OP_SHL, OP_SHR).
  - state enum (IDLE, ALIGN, RUN, DONE).
  - MC_LEN default and step-count width.
- One sub-module, ccu_digit_timer: the free-running p.i. counter with d0/d35 decode. It is reusable by other CCUs.
- Sequencer FSM, order latch and step counter live in ccu_seq.

## Test plan
- Reset release, then multiply, long_num=0, start at p.i. 10 → RUN from next d0; 17 c7 pulses; done once; step=17; c5 high throughout RUN; c6=0.
- Shift left count=5, start at p.i. 35 → ALIGN exits the following cycle's minor cycle end (next d35); c6=1, s2=1 for 5·36 cycles; step=5; done 1 cycle later.
- Shift right count=0 → no RUN, no c7; done one cycle after the next d35; step=0.
- Shift with count=50 → saturates to 35 steps; second start during RUN → ovr pulse, order unchanged.
- rst asserted in RUN step 8 → all outputs at reset values at once, p.i.=0, no done; new order after release completes normally.
- With CCU_SEQ_ABORT_EN: long multiply, abort at step 3 mid-cycle → DONE after that minor cycle's d35; step=4; done pulses once.
